// File: rtl/io_port_if.sv
// io_port_if: processor-bus and output-sink signals of the io_port peripheral.
// The shared bidirectional data bus is kept as a plain inout on io_port so the
// tristate resolves at the top level together with the RAM drivers.
interface io_port_if;
  logic [7:0] address;    // processor bus address
  logic       we;         // 1 = store
  logic       io_sel;     // peripheral window 0xF0-0xFF selected
  logic [7:0] out_data;   // FIFO head byte
  logic       out_valid;  // FIFO non-empty
  logic       out_ready;  // sink accepts out_data this cycle

  // Processor / sink side
  modport master (
    output address, we, out_ready,
    input  io_sel, out_data, out_valid
  );

  // Peripheral side
  modport slave (
    input  address, we, out_ready,
    output io_sel, out_data, out_valid
  );
endinterface

// File: rtl/io_port.sv
// io_port: memory-mapped output FIFO + free-running timer at 0xF0-0xFF.
//   0xFC OUT    W: push byte, R: 0x00
//   0xFD STATUS {0, ovf, count[3:0], full, empty}; W bit6=1 clears ovf
//   0xFE TIMER  R/W 8-bit counter (only when IO_TIMER_EN is defined)
// Optional feature macro: IO_TIMER_EN (undefined: no timer flops, 0xFE reads 0).
// DEPTH must be 2, 4 or 8 so pointers wrap naturally and count fits 4 bits.
module io_port #(
  parameter int DEPTH = 8
) (
  input  logic      clock,
  input  logic      reset,
  inout  wire [7:0] data,
  io_port_if.slave  bus
);

  localparam int         PW       = $clog2(DEPTH);
  localparam logic [7:0] A_OUT    = 8'hFC;
  localparam logic [7:0] A_STAT   = 8'hFD;
  localparam logic [7:0] A_TMR    = 8'hFE;
  localparam logic [3:0] FULL_CNT = 4'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          ovf_q, ovf_d;

  logic          io_sel, wr_en, push_req, push, pop, full, empty;
  logic          ovf_set, ovf_clr;
  logic [7:0]    tmr_rd, rd_data, status;

  // Address decode is purely combinational and ignores we
  assign io_sel     = (bus.address[7:4] == 4'hF);
  assign bus.io_sel = io_sel;
  assign wr_en      = io_sel & bus.we;

  assign empty    = (cnt_q == 4'd0);
  assign full     = (cnt_q == FULL_CNT);
  assign push_req = wr_en & (bus.address == A_OUT);
  // Full test uses pre-edge state: a same-cycle pop never makes room
  assign push     = push_req & ~full;
  assign pop      = ~empty & bus.out_ready;
  assign ovf_set  = push_req & full;
  assign ovf_clr  = wr_en & (bus.address == A_STAT) & data[6];

  assign bus.out_valid = ~empty;
  assign bus.out_data  = empty ? 8'h00 : mem_q[rptr_q];

  // Next-state for pointers, count and sticky overflow (set wins over clear)
  always_comb begin
    wptr_d = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d = pop  ? rptr_q + PW'(1) : rptr_q;
    cnt_d  = cnt_q + {3'b000, push} - {3'b000, pop};
    ovf_d  = ovf_set | (ovf_q & ~ovf_clr);
  end

  // FIFO control state, cleared asynchronously
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= 4'd0;
      ovf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  // Storage needs no reset: empty gates out_data and pointers restart at 0
  always_ff @(posedge clock) begin
    if (push) mem_q[wptr_q] <= data;
  end

`ifdef IO_TIMER_EN
  logic [7:0] tmr_q, tmr_d;

  // Load on write, otherwise count up and wrap
  always_comb begin
    tmr_d = tmr_q + 8'd1;
    if (wr_en && bus.address == A_TMR) tmr_d = data;
  end

  // Timer register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) tmr_q <= 8'h00;
    else       tmr_q <= tmr_d;
  end

  assign tmr_rd = tmr_q;
`else
  assign tmr_rd = 8'h00;
`endif

  assign status = {1'b0, ovf_q, cnt_q, full, empty};

  // Zero-wait-state read mux from current register state
  always_comb begin
    rd_data = 8'h00;
    case (bus.address)
      A_STAT:  rd_data = status;
      A_TMR:   rd_data = tmr_rd;
      default: rd_data = 8'h00;
    endcase
  end

  // Drive the shared bus only on peripheral reads; RAM owns it otherwise
  assign data = (io_sel && !bus.we) ? rd_data : 8'hzz;

endmodule

// File: tb/tb_io_port.sv
// tb_io_port: scoreboard bench for io_port (DEPTH=8). Expected FIFO bytes are
// queued when a push is driven and compared when the sink pops them.
module tb_io_port;
  localparam int DEPTH = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] drv = 8'h00;
  logic       drv_en = 1'b0;
  wire  [7:0] data;

  io_port_if bus ();

  assign data = drv_en ? drv : 8'hzz;

  io_port #(.DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .data  (data),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int         n_chk = 0;
  int         n_err = 0;
  logic [7:0] sb_q[$];
  logic       m_ovf = 1'b0;
  logic [7:0] m_tmr = 8'h00;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%02h exp=0x%02h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_status();
    logic [3:0] c;
    c = 4'(sb_q.size());
    return {1'b0, m_ovf, c, (c == 4'(DEPTH)), (c == 4'd0)};
  endfunction

  // One bus cycle: drive, model the edge, check pop data before and FIFO head after
  task automatic cyc(input logic [7:0] a, input logic w, input logic [7:0] d, input logic rdy);
    logic       pre_full, set, clr;
    logic [7:0] e;
    bus.address   = a;
    bus.we        = w;
    bus.out_ready = rdy;
    drv           = d;
    drv_en        = w;
    #1;
    pre_full = (sb_q.size() == DEPTH);
    if (rdy && sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk("pop_data", bus.out_data, e);
    end
    set = w && a == 8'hFC && pre_full;
    clr = w && a == 8'hFD && d[6];
    if (w && a == 8'hFC && !pre_full) sb_q.push_back(d);
    m_ovf = set | (m_ovf & ~clr);
`ifdef IO_TIMER_EN
    m_tmr = (w && a == 8'hFE) ? d : m_tmr + 8'd1;
`endif
    @(posedge clock);
    #1;
    chk("out_valid", {7'd0, bus.out_valid}, {7'd0, sb_q.size() != 0});
    chk("out_data", bus.out_data, (sb_q.size() != 0) ? sb_q[0] : 8'h00);
  endtask

  // Combinational read within the current cycle (no edge consumed)
  task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
    bus.address = a;
    bus.we      = 1'b0;
    drv_en      = 1'b0;
    #1;
    chk(tag, data, exp);
  endtask

  initial begin
    bus.address   = 8'h00;
    bus.we        = 1'b0;
    bus.out_ready = 1'b0;
    #2;
    // Reset state and decode while reset is held
    chk("rst_valid", {7'd0, bus.out_valid}, 8'd0);
    chk("rst_data", bus.out_data, 8'h00);
    chk("rst_iosel_lo", {7'd0, bus.io_sel}, 8'd0);
    rd("rst_status", 8'hFD, 8'h01);
    chk("rst_iosel_hi", {7'd0, bus.io_sel}, 8'd1);
    @(posedge clock); #1;
    reset = 1'b0;

    // Three pushes, sink stalled
    cyc(8'hFC, 1, 8'h01, 0);
    cyc(8'hFC, 1, 8'h01, 0);
    cyc(8'hFC, 1, 8'h02, 0);
    rd("st_three", 8'hFD, 8'h0C);
    chk("head_three", bus.out_data, 8'h01);
    chk("valid_three", {7'd0, bus.out_valid}, 8'd1);
    repeat (3) cyc(8'h00, 0, 8'h00, 1);
    rd("st_drained", 8'hFD, exp_status());

    // Overfill: nine pushes into eight slots
    for (int i = 0; i < 9; i++) cyc(8'hFC, 1, 8'(8'h10 + i), 0);
    rd("st_overflow", 8'hFD, 8'h62);
    cyc(8'hFD, 1, 8'h40, 0);
    rd("st_ovf_clr", 8'hFD, 8'h22);
    // Full, pop and push in one cycle: byte dropped, overflow set
    cyc(8'hFC, 1, 8'hAA, 1);
    rd("st_full_pushpop", 8'hFD, 8'h5C);
    repeat (7) cyc(8'h00, 0, 8'h00, 1);
    rd("st_empty_ovf", 8'hFD, 8'h41);
    cyc(8'hFD, 1, 8'hBF, 0);
    rd("st_noclr", 8'hFD, 8'h41);
    cyc(8'hFD, 1, 8'h40, 0);
    rd("st_clr", 8'hFD, 8'h01);

    // Single entry, simultaneous push/pop
    cyc(8'hFC, 1, 8'h33, 0);
    cyc(8'hFC, 1, 8'h55, 1);
    rd("st_one", 8'hFD, 8'h04);
    chk("head_55", bus.out_data, 8'h55);
    cyc(8'h00, 0, 8'h00, 1);

    // Writes outside the window or to read-only/unmapped registers are ignored
    cyc(8'h0C, 1, 8'h99, 0);
    cyc(8'hF3, 1, 8'h99, 0);
    cyc(8'hFD, 1, 8'h3F, 0);
    rd("st_ignored", 8'hFD, 8'h01);
    rd("rd_out", 8'hFC, 8'h00);
    rd("rd_unmapped", 8'hF0, 8'h00);
    rd("rd_ff", 8'hFF, 8'h00);

    // Timer load and wrap
    cyc(8'hFE, 1, 8'hFE, 0);
    rd("tmr_load", 8'hFE, m_tmr);
    cyc(8'h00, 0, 8'h00, 0);
    rd("tmr_next1", 8'hFE, m_tmr);
    cyc(8'h00, 0, 8'h00, 0);
`ifdef IO_TIMER_EN
    rd("tmr_wrap", 8'hFE, 8'h00);
`else
    rd("tmr_off", 8'hFE, 8'h00);
`endif

    // Below the window the peripheral must leave the bus to RAM
    bus.address = 8'h20;
    bus.we      = 1'b0;
    drv         = 8'h5A;
    drv_en      = 1'b1;
    #1;
    chk("ram_bus", data, 8'h5A);
    chk("ram_iosel", {7'd0, bus.io_sel}, 8'd0);
    drv_en = 1'b0;

    // Randomised traffic exercises pointer wrap and occupancy
    for (int i = 0; i < 60; i++) begin
      logic [7:0] a;
      a = ($urandom_range(0, 3) != 0) ? 8'hFC : 8'hF5;
      cyc(a, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) == 0));
      if (i % 8 == 0) rd("st_rand", 8'hFD, exp_status());
    end

    // Asynchronous reset mid-transfer discards contents
    cyc(8'hFC, 1, 8'hC1, 0);
    cyc(8'hFC, 1, 8'hC2, 1);
    bus.out_ready = 1'b1;
    #2;
    reset = 1'b1;
    sb_q.delete();
    m_ovf = 1'b0;
    m_tmr = 8'h00;
    #1;
    chk("arst_valid", {7'd0, bus.out_valid}, 8'd0);
    rd("arst_status", 8'hFD, 8'h01);
    rd("arst_tmr", 8'hFE, 8'h00);
    @(posedge clock); #1;
    chk("arst_hold", {7'd0, bus.out_valid}, 8'd0);
    reset = 1'b0;
    cyc(8'hFC, 1, 8'h7E, 0);
    rd("post_rst", 8'hFD, 8'h04);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/io_port.md
IO_PORT -- requirements
Module: io_port

Memory-mapped output/timer peripheral on the uP data bus, alongside the RAM. It consumes processor stores to 0xF0-0xFF and buffers output bytes for an external sink.

Interface
REQ-001 SHALL have parameter DEPTH, default 8, output FIFO depth in bytes; legal values 2, 4, 8.
REQ-002 SHALL have port clock  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port address  input  8  processor bus address.
REQ-005 SHALL have port we  input  1  processor write enable, 1 = store.
REQ-006 SHALL have port data  inout  8  shared processor/memory data bus.
REQ-007 SHALL have port io_sel  output  1  high when address[7:4]==4'hF; system uses it to disable RAM read drive.
REQ-008 SHALL have port out_data  output  8  FIFO head byte.
REQ-009 SHALL have port out_valid  output  1  FIFO non-empty.
REQ-010 SHALL have port out_ready  input  1  sink accepts out_data this cycle.

Function
REQ-011 SHALL decode io_sel combinationally from address alone, independent of we.
REQ-012 SHALL drive data only when io_sel=1 and we=0; otherwise data SHALL be high-Z.
REQ-013 SHALL return read data combinationally from current register state: no wait states; valid in the same cycle as the address.
REQ-014 Register map: 0xFC OUT (W: push byte; R: 0x00); 0xFD STATUS; 0xFE TIMER (R/W); all other 0xF0-0xFF addresses read 0x00 and ignore writes.
REQ-015 STATUS fields:
  - bit0 = empty.
  - bit1 = full.
  - bits5:2 = occupancy count 0..DEPTH.
  - bit6 = sticky overflow.
  - bit7 = 0.
REQ-016 Write to 0xFC with we=1 SHALL push data at the clock edge when the FIFO is not full.
REQ-017 Push when full SHALL:
  - drop the byte;
  - set overflow;
  - apply the full test to the pre-edge state, even if a pop occurs in the same cycle.
REQ-018 Pop SHALL occur when out_valid=1 and out_ready=1 at the clock edge.
REQ-019 out_data SHALL be the head entry and out_valid SHALL equal !empty, both registered-state derived.
REQ-020 Simultaneous legal push and pop SHALL leave the count unchanged and preserve FIFO order.
REQ-021 Push into an empty FIFO SHALL raise out_valid on the cycle after the edge (one-cycle latency).
REQ-022 Read/write pointers SHALL be log2(DEPTH) bits, wrapping modulo DEPTH; count SHALL be held separately in 4 bits.
REQ-023 Writing 0xFD with data bit6=1 SHALL clear overflow; other bits are read-only.
REQ-024 Overflow set and clear in the same cycle SHALL resolve to set.
REQ-025 TIMER SHALL be an 8-bit counter that increments every cycle and wraps 0xFF->0x00.
REQ-026 Writing 0xFE SHALL load the written value, and the counter SHALL increment from that value on the next cycle.
REQ-027 Writes SHALL require io_sel=1 and we=1 at the edge; data bus contents outside that condition SHALL be ignored.

Reset
REQ-028 On reset assertion, SHALL asynchronously clear:
  - pointers and count to 0;
  - overflow to 0;
  - TIMER to 0x00.
  This forces out_valid=0 and out_data=0x00.
REQ-029 Reset asserted mid-transfer SHALL discard all FIFO contents; no pop or push completes on that edge.
REQ-030 While reset=1, data SHALL still follow REQ-012 (combinational decode); io_sel SHALL follow REQ-011.

Configuration
REQ-031 Macro IO_TIMER_EN defined: TIMER register at 0xFE present as in REQ-025/026.
REQ-032 Macro IO_TIMER_EN undefined: no timer flops, 0xFE reads 0x00, writes to 0xFE ignored; all other behaviour identical.

Verification
REQ-033 Reset, then push 0x01,0x01,0x02 to 0xFC with out_ready=0 -> STATUS reads 0x0C; out_data=0x01; out_valid=1.
REQ-034 Push 9 bytes 0x10..0x18 with DEPTH=8 and out_ready=0 -> STATUS=0x62 (full, count 8, overflow); popped sequence 0x10..0x17.
REQ-035 Write 0x40 to 0xFD after overflow -> STATUS bit6=0 next cycle, other fields unchanged.
REQ-036 FIFO full and out_ready=1 while pushing 0xAA in the same cycle -> byte dropped, overflow set, count 7 next cycle.
REQ-037 One entry, simultaneous push 0x55 and pop -> count stays 1, out_data=0x55 next cycle.
REQ-038 With IO_TIMER_EN, write 0xFE=0xFE, then read 0xFE on the next two cycles -> 0xFF then 0x00. Without IO_TIMER_EN, reads return 0x00; on any read, data is high-Z when address<0xF0.
